// File: rtl/fft_addr_gen_pkg.sv
// -----------------------------------------------------------------------------
// fft_addr_gen_pkg
//   Shared constants for the radix-2 DIT FFT datapath.
//   FFT_STAGE : log2 of the transform size; default LOG2N of the sequencer
//   FFT_BITS  : datapath sample width used by the butterfly / LUT blocks
//   FFT_N     : transform size derived from FFT_STAGE
//   GAP_W     : width of the inter-stage drain counter (gaps of 0..255 cycles)
// -----------------------------------------------------------------------------
package fft_addr_gen_pkg;

  localparam int FFT_STAGE = 4;
  localparam int FFT_BITS  = 16;
  localparam int FFT_N     = 1 << FFT_STAGE;
  localparam int GAP_W     = 8;

endpackage : fft_addr_gen_pkg

// File: rtl/fft_bit_reverse.sv
// -----------------------------------------------------------------------------
// fft_bit_reverse
//   Purely combinational WIDTH-bit reverser, used to generate the
//   bit-reversed load order in front of the in-place FFT.
//   Ports:
//     value    in  WIDTH  natural-order index
//     reversed out WIDTH  value with its bit order mirrored
// -----------------------------------------------------------------------------
module fft_bit_reverse #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] reversed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign reversed[i] = value[WIDTH-1-i];
  end

endmodule : fft_bit_reverse

// File: rtl/fft_addr_gen.sv
// -----------------------------------------------------------------------------
// fft_addr_gen
//   Address / twiddle sequencer for the in-place radix-2 DIT FFT. After a
//   start pulse it walks every stage s and butterfly j, presenting one
//   registered beat per accepted cycle: operand addresses addr_a/addr_b and
//   the twiddle LUT index. Downstream stall freezes it; an optional drain gap
//   of STAGE_GAP idle cycles separates stages.
//
//   Optional feature: define FFT_ADDR_GEN_BITREV_EN to insert a LOAD phase of
//   N beats (addr_a = bitrev(k)) between IDLE and RUN.
//
//   Ports:
//     clk         in   rising-edge clock
//     rst         in   asynchronous active-high reset
//     start       in   begin transform, sampled only in IDLE
//     stall       in   downstream not ready; freezes LOAD/RUN/GAP
//     busy        out  transform in progress (through DONE)
//     valid       out  addr_a/addr_b/tw_index carry a live beat
//     addr_a      out  top operand address
//     addr_b      out  bottom operand address (addr_a + 2^s)
//     tw_index    out  twiddle LUT index, MSB always 0
//     stage       out  current stage s
//     stage_last  out  beat is the last of its stage (or of LOAD)
//     done        out  one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module fft_addr_gen
  import fft_addr_gen_pkg::*;
#(
  parameter int LOG2N     = FFT_STAGE,
  parameter int STAGE_GAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             valid,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N:0]   tw_index,
  output logic [LOG2N-1:0] stage,
  output logic             stage_last,
  output logic             done
);

  localparam int N    = 1 << LOG2N;
  localparam int HALF = N / 2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);
  localparam logic [LOG2N-1:0] J_LAST   = LOG2N'(HALF - 1);
  localparam logic [LOG2N-1:0] S_LAST   = LOG2N'(LOG2N - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);
  localparam bit               HAS_GAP  = (STAGE_GAP > 0);

  // State and counters. j doubles as the LOAD index k (0..N-1), hence LOG2N bits.
  logic [2:0]       state_q, state_d;
  logic [LOG2N-1:0] s_q, s_d;
  logic [LOG2N-1:0] j_q, j_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  // Next values of the registered outputs.
  logic             busy_d, valid_d, stage_last_d, done_d;
  logic [LOG2N-1:0] addr_a_d, addr_b_d, stage_d;
  logic [LOG2N:0]   tw_index_d;

  // Beat math scratch.
  logic [LOG2N-1:0] h, pos, grp, beat_a, tw;

`ifdef FFT_ADDR_GEN_BITREV_EN
  localparam logic [LOG2N-1:0] K_LAST = LOG2N'(N - 1);
  logic [LOG2N-1:0] rev_k;

  fft_bit_reverse #(.WIDTH(LOG2N)) u_bit_reverse (
    .value    (j_d),
    .reversed (rev_k)
  );
`endif

  // ---------------------------------------------------------------------------
  // State register. Outputs are registered here from their next values so
  // every output, including the async-reset value, comes straight off a flop.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      j_q        <= '0;
      gap_q      <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      addr_a     <= '0;
      addr_b     <= '0;
      tw_index   <= '0;
      stage      <= '0;
      stage_last <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      j_q        <= j_d;
      gap_q      <= gap_d;
      busy       <= busy_d;
      valid      <= valid_d;
      addr_a     <= addr_a_d;
      addr_b     <= addr_b_d;
      tw_index   <= tw_index_d;
      stage      <= stage_d;
      stage_last <= stage_last_d;
      done       <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A stall leaves every *_d equal to its *_q, which is what
  // freezes both the counters and the registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path can infer
  // a latch.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    gap_d   = gap_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef FFT_ADDR_GEN_BITREV_EN
          state_d = ST_LOAD;
`else
          state_d = ST_RUN;
`endif
          s_d   = '0;
          j_d   = '0;
          gap_d = '0;
        end
      end

`ifdef FFT_ADDR_GEN_BITREV_EN
      ST_LOAD: begin
        if (!stall) begin
          if (j_q == K_LAST) begin
            state_d = ST_RUN;
            j_d     = '0;
          end else begin
            j_d = j_q + ONE;
          end
        end
      end
`endif

      ST_RUN: begin
        if (!stall) begin
          if (j_q == J_LAST) begin
            j_d = '0;
            if (s_q == S_LAST) begin
              state_d = ST_DONE;
            end else if (HAS_GAP) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end else begin
              s_d = s_q + ONE;
            end
          end else begin
            j_d = j_q + ONE;
          end
        end
      end

      ST_GAP: begin
        if (!stall) begin
          if (gap_q == GAP_LAST) begin
            state_d = ST_RUN;
            s_d     = s_q + ONE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        s_d     = '0;
      end

      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
        j_d     = '0;
        gap_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic, evaluated on the next state so the registered outputs line
  // up with the beat the counters will hold after the edge.
  // For h = 2^s: butterfly j sits in group j>>s at offset j&(h-1); groups are
  // 2h apart, and the twiddle step is N/(2h), i.e. pos << (LOG2N-1-s).
  // ---------------------------------------------------------------------------
  always_comb begin
    h      = ONE << s_d;
    pos    = j_d & (h - ONE);
    grp    = j_d >> s_d;
    beat_a = (grp << (s_d + ONE)) | pos;
    tw     = pos << (S_LAST - s_d);

    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    valid_d      = 1'b0;
    addr_a_d     = '0;
    addr_b_d     = '0;
    tw_index_d   = '0;
    stage_d      = '0;
    stage_last_d = 1'b0;

    case (state_d)
      ST_RUN: begin
        valid_d      = 1'b1;
        addr_a_d     = beat_a;
        addr_b_d     = beat_a + h;
        tw_index_d   = {1'b0, tw};
        stage_d      = s_d;
        stage_last_d = (j_d == J_LAST);
      end
      ST_GAP: begin
        stage_d = s_d;
      end
`ifdef FFT_ADDR_GEN_BITREV_EN
      ST_LOAD: begin
        valid_d      = 1'b1;
        addr_a_d     = rev_k;
        stage_last_d = (j_d == K_LAST);
      end
`endif
      default: ;
    endcase
  end

endmodule : fft_addr_gen
